// File: rtl/event_flasher_if.sv
// event_flasher_if: event request in, LED drive and queue status out.
interface event_flasher_if #(parameter int PW = 3);
  logic event_in;
  logic led_out;
  logic busy;
  logic [PW-1:0] pending;
  logic overflow;
  modport master (output event_in, input led_out, busy, pending, overflow);
  modport slave (input event_in, output led_out, busy, pending, overflow);
endinterface

// File: rtl/event_flasher.sv
// event_flasher: turns event pulses into LED flashes with minimum on/off times and a saturating replay queue.
// Define EVENT_FLASHER_ACTIVE_LOW_EN to drive led_out active-low.
module event_flasher #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int ON_MS = 100,
  parameter int OFF_MS = 100,
  parameter int MAX_PENDING = 7
) (
  input logic clk,
  input logic rst_n,
  event_flasher_if.slave bus
);
  localparam int ON_CYCLES = (CLK_FREQ / 1000) * ON_MS;
  localparam int OFF_CYCLES = (CLK_FREQ / 1000) * OFF_MS;
  localparam int TW = $clog2((ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES) + 1);
  localparam int PW = $clog2(MAX_PENDING + 1);
`ifdef EVENT_FLASHER_ACTIVE_LOW_EN
  localparam logic LED_ON = 1'b0;
`else
  localparam logic LED_ON = 1'b1;
`endif
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [PW-1:0] pending;
  logic led, overflow, queued, full, start;
  assign queued = pending != '0;
  assign full = pending == PW'(MAX_PENDING);
  assign start = (state == IDLE || (state == OFF && timer == '0)) && (bus.event_in || queued);
  // A flash start eats the queued event first; a simultaneous new event takes its place.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      pending <= '0;
      overflow <= 1'b0;
      led <= ~LED_ON;
    end else begin
      overflow <= 1'b0;
      if (start) begin
        state <= ON;
        timer <= TW'(ON_CYCLES - 1);
        led <= LED_ON;
        if (queued && !bus.event_in) pending <= pending - PW'(1);
      end else begin
        if (bus.event_in) begin
          if (full) overflow <= 1'b1;
          else pending <= pending + PW'(1);
        end
        if (state == ON && timer == '0) begin
          state <= OFF;
          timer <= TW'(OFF_CYCLES - 1);
          led <= ~LED_ON;
        end else if (state == OFF && timer == '0) state <= IDLE;
        else if (state != IDLE) timer <= timer - TW'(1);
      end
    end
  assign bus.led_out = led;
  assign bus.busy = state != IDLE || queued;
  assign bus.pending = pending;
  assign bus.overflow = overflow;
endmodule
